sparse_scatter: RTL and testbench
=================================

// Module: sparse_scatter
// PURPOSE
//  Output-side expander for the sparse filter datapath. It takes a compacted vector of up
//  to N_VALS values plus a LENGTH-bit occupancy mask, and rebuilds the dense LENGTH-slot
//  vector: the k-th set mask bit receives compacted value k, and every clear position is 0.
//  It is sequential, one mask position per cycle, with the same ready/taken handshake style
//  as the filter stage.
// PARAMETERS
//  IL      8                   integer bits of each fixed-point value
//  FL      12                  fractional bits; W = IL+FL = value width
//  LENGTH  32                  dense positions / mask width
//  N_VALS  16                  compacted value slots
//  P_LEN   $clog2(LENGTH)      position pointer width
//  C_LEN   $clog2(N_VALS+1)    count width
// PORTS
//  clk           in   1           clock
//  reset         in   1           synchronous, active-high reset
//  in_vals       in   N_VALS*W    compacted values; slot k = in_vals[k*W +: W], signed
//  in_mask       in   LENGTH      occupancy mask; bit p=1 -> dense position p is occupied
//  input_ready   in   1           producer has valid in_vals/in_mask
//  output_taken  in   1           consumer has read the results
//  input_taken   out  1           one-cycle pulse: inputs were latched
//  out_dense     out  LENGTH*W    dense result; position p = out_dense[p*W +: W]
//  out_count     out  C_LEN       number of values placed, saturates at N_VALS
//  overflow      out  1           mask had more than N_VALS set bits
//  state         out  2           00 IDLE, 01 BUSY, 10 DONE
// BEHAVIOUR
//  - Reset: clk and reset are as listed under PORTS.
//    Reset sets state=00, input_taken=0, out_dense=0, out_count=0, overflow=0.
//    It also clears the internal pointers and latched inputs.
//    Reset has priority in every state, including mid-BUSY.
//  - IDLE & input_ready=1:
//    latch in_vals and in_mask; m_ptr=0, v_ptr=0.
//    Clear out_dense, out_count and overflow.
//    input_taken=1 for exactly this one cycle. Next state is BUSY.
//  - BUSY, per cycle, at position p=m_ptr:
//    mask[p]=1 & v_ptr<N_VALS  -> out_dense[p] <= vals[v_ptr]; v_ptr++.
//    mask[p]=1 & v_ptr==N_VALS -> overflow <= 1; position p stays 0.
//    mask[p]=0                 -> position p stays 0.
//    m_ptr++ every cycle. When p==LENGTH-1 has been processed, the next state is DONE.
//  - Latency: inputs are accepted at edge t; BUSY covers edges t+1 .. t+LENGTH; state=10
//    is visible after edge t+LENGTH. The latency is independent of the mask contents.
//  - DONE: out_dense, out_count and overflow are held stable; out_count = v_ptr.
//    output_taken=1 -> state=00 next cycle, and out_dense, out_count, overflow are cleared.
//  - Ignored inputs: input_ready in BUSY or DONE, and output_taken in IDLE or BUSY.
//  - In_vals/in_mask changes after acceptance have no effect.
//  - Values are copied bit-exact (signed W bits); no rounding, saturation or sign change.
//  - Boundaries:
//    mask=0 gives all-zero output, count 0, and still LENGTH BUSY cycles.
//    With exactly N_VALS set bits: count=N_VALS, overflow=0.
//    m_ptr does not wrap inside a transaction.
// TESTING
//  1. vals slot k=k+1, mask=32'h0000_00A5 -> pos0=1, pos2=2, pos5=3, pos7=4, others 0;
//     count=4, ovf=0; state=10 exactly 32 edges after the accept edge.
//  2. mask=0, vals nonzero -> out_dense all 0, count=0, ovf=0; DONE after 32 BUSY cycles.
//  3. mask=32'hFFFF_FFFF, slot k=20'h00100+k -> pos0..15 = 0x100..0x10F, pos16..31 = 0;
//     count=16, ovf=1.
//  4. slot0=20'hFFFFF, slot1=20'h80000, mask=32'h8000_0001
//     -> pos0=20'hFFFFF, pos31=20'h80000 (sign bits preserved).
//  5. Assert reset on the 10th BUSY cycle -> next cycle state=00, all outputs 0.
//     A following transaction (test 1 stimulus) gives the test 1 result.
//  6. Handshake:
//     input_taken is high for 1 cycle only.
//     output_taken during BUSY is ignored, and so is input_ready held high in DONE.
//     output_taken in DONE -> state 00 and outputs 0 next cycle.
//     Then, with input_ready still high, a new accept occurs one cycle later.

Source files
------------

// File: rtl/sparse_scatter.sv
// Expands a compacted value vector into a dense LENGTH-slot vector under an occupancy mask,
// walking one mask position per cycle behind a ready/taken handshake.
module sparse_scatter #(
  parameter int IL     = 8,
  parameter int FL     = 12,
  parameter int LENGTH = 32,
  parameter int N_VALS = 16,
  parameter int P_LEN  = $clog2(LENGTH),
  parameter int C_LEN  = $clog2(N_VALS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_VALS*(IL+FL)-1:0]    in_vals,
  input  logic [LENGTH-1:0]            in_mask,
  input  logic                         input_ready,
  input  logic                         output_taken,
  output logic                         input_taken,
  output logic [LENGTH*(IL+FL)-1:0]    out_dense,
  output logic [C_LEN-1:0]             out_count,
  output logic                         overflow,
  output logic [1:0]                   state
);

  localparam int W = IL + FL;
  localparam logic [C_LEN-1:0] FULL_CNT = C_LEN'(N_VALS);
  localparam logic [P_LEN-1:0] LAST_POS = P_LEN'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [N_VALS*W-1:0]     vals_q, vals_d;
  logic [LENGTH-1:0]       mask_q, mask_d;
  logic [P_LEN-1:0]        m_ptr_q, m_ptr_d;
  logic [C_LEN-1:0]        v_ptr_q, v_ptr_d;
  logic [LENGTH*W-1:0]     dense_q, dense_d;
  logic                    ovf_q, ovf_d;
  logic                    taken_q, taken_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    vals_d  = vals_q;
    mask_d  = mask_q;
    m_ptr_d = m_ptr_q;
    v_ptr_d = v_ptr_q;
    dense_d = dense_q;
    ovf_d   = ovf_q;
    taken_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (input_ready) begin
          vals_d  = in_vals;
          mask_d  = in_mask;
          m_ptr_d = '0;
          v_ptr_d = '0;
          dense_d = '0;
          ovf_d   = 1'b0;
          taken_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Occupied slots beyond the last compacted value flag overflow and stay zero.
        if (mask_q[m_ptr_q]) begin
          if (v_ptr_q != FULL_CNT) begin
            dense_d[int'(m_ptr_q)*W +: W] = vals_q[int'(v_ptr_q)*W +: W];
            v_ptr_d = v_ptr_q + C_LEN'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        m_ptr_d = m_ptr_q + P_LEN'(1);
        if (m_ptr_q == LAST_POS) begin
          m_ptr_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (output_taken) begin
          dense_d = '0;
          v_ptr_d = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vals_q  <= '0;
      mask_q  <= '0;
      m_ptr_q <= '0;
      v_ptr_q <= '0;
      dense_q <= '0;
      ovf_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vals_q  <= vals_d;
      mask_q  <= mask_d;
      m_ptr_q <= m_ptr_d;
      v_ptr_q <= v_ptr_d;
      dense_q <= dense_d;
      ovf_q   <= ovf_d;
      taken_q <= taken_d;
    end
  end

  assign input_taken = taken_q;
  assign out_dense   = dense_q;
  assign out_count   = v_ptr_q;
  assign overflow    = ovf_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sparse_scatter.sv
// Scoreboard bench for sparse_scatter: a driver issues directed and random transactions,
// a monitor compares each DONE result against a mask-walking reference model.
module tb_sparse_scatter;

  localparam int IL     = 8;
  localparam int FL     = 12;
  localparam int W      = IL + FL;
  localparam int LENGTH = 32;
  localparam int N_VALS = 16;
  localparam int P_LEN  = $clog2(LENGTH);
  localparam int C_LEN  = $clog2(N_VALS + 1);
  localparam int VW     = N_VALS * W;
  localparam int DW     = LENGTH * W;

  logic              clk;
  logic              reset;
  logic [VW-1:0]     in_vals;
  logic [LENGTH-1:0] in_mask;
  logic              input_ready;
  logic              output_taken;
  logic              input_taken;
  logic [DW-1:0]     out_dense;
  logic [C_LEN-1:0]  out_count;
  logic              overflow;
  logic [1:0]        state;

  sparse_scatter #(
    .IL(IL), .FL(FL), .LENGTH(LENGTH), .N_VALS(N_VALS), .P_LEN(P_LEN), .C_LEN(C_LEN)
  ) dut (
    .clk(clk), .reset(reset), .in_vals(in_vals), .in_mask(in_mask),
    .input_ready(input_ready), .output_taken(output_taken), .input_taken(input_taken),
    .out_dense(out_dense), .out_count(out_count), .overflow(overflow), .state(state)
  );

  typedef struct {
    logic [DW-1:0]    dense;
    logic [C_LEN-1:0] cnt;
    logic             ovf;
    int               accept_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk mask positions, hand out compacted values in order until they run out.
  function automatic exp_t model(input logic [VW-1:0] v, input logic [LENGTH-1:0] m);
    exp_t e;
    int k = 0;
    e.dense = '0;
    e.ovf   = 1'b0;
    for (int p = 0; p < LENGTH; p++) begin
      if (m[p]) begin
        if (k < N_VALS) begin
          e.dense[p*W +: W] = v[k*W +: W];
          k++;
        end else begin
          e.ovf = 1'b1;
        end
      end
    end
    e.cnt = C_LEN'(k);
    e.accept_edge = 0;
    return e;
  endfunction

  function automatic logic [VW-1:0] seq_vals(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < N_VALS; k++) v[k*W +: W] = W'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vals();
    logic [VW-1:0] v;
    for (int k = 0; k < N_VALS; k++) v[k*W +: W] = W'($urandom());
    return v;
  endfunction

  // Monitor: scores each entry into DONE and polices the input_taken pulse width.
  logic [1:0] prev_state = 2'b00;
  logic       prev_taken = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_taken) check("taken_pulse", DW'(input_taken), DW'(0));
    if (!reset && state == 2'b10 && prev_state != 2'b10) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE with no transaction pending");
      end else begin
        e = exp_q.pop_front();
        check("dense", out_dense, e.dense);
        check("count", DW'(out_count), DW'(e.cnt));
        check("overflow", DW'(overflow), DW'(e.ovf));
        check("latency", DW'(edge_cnt - e.accept_edge), DW'(LENGTH));
      end
    end
    prev_state = state;
    prev_taken = input_taken;
  end

  task automatic start_tx(input logic [VW-1:0] v, input logic [LENGTH-1:0] m, input bit immediate);
    exp_t e;
    bit got = 1'b0;
    if (immediate) begin
      @(negedge clk);
      check("reaccept", DW'(input_taken), DW'(1));
      got = input_taken;
    end else begin
      in_vals = v;
      in_mask = m;
      input_ready = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        got = input_taken;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no input_taken expected a pulse");
    end else begin
      e = model(v, m);
      e.accept_edge = edge_cnt;
      exp_q.push_back(e);
    end
  endtask

  // Toggles output_taken randomly while BUSY, which the DUT must ignore.
  task automatic wait_done();
    for (int i = 0; i < LENGTH + 8; i++) begin
      @(negedge clk);
      if (state == 2'b10) break;
      output_taken = 1'($urandom_range(0, 1));
    end
    output_taken = 1'b0;
    check("reach_done", DW'(state), DW'(2'b10));
  endtask

  task automatic hold_done(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("done_hold", DW'(state), DW'(2'b10));
    end
  endtask

  task automatic release_done();
    output_taken = 1'b1;
    @(negedge clk);
    output_taken = 1'b0;
    check("rel_state", DW'(state), DW'(0));
    check("rel_dense", out_dense, DW'(0));
    check("rel_count", DW'(out_count), DW'(0));
    check("rel_ovf", DW'(overflow), DW'(0));
  endtask

  task automatic full_tx(input logic [VW-1:0] v, input logic [LENGTH-1:0] m);
    start_tx(v, m, 1'b0);
    input_ready = 1'b0;
    in_vals = rand_vals();
    in_mask = $urandom();
    wait_done();
    hold_done($urandom_range(0, 3));
    release_done();
  endtask

  initial begin
    logic [VW-1:0]     v;
    logic [LENGTH-1:0] m;

    reset = 1'b1;
    in_vals = '0;
    in_mask = '0;
    input_ready = 1'b0;
    output_taken = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", DW'(state), DW'(0));
    check("rst_dense", out_dense, DW'(0));
    check("rst_count", DW'(out_count), DW'(0));
    check("rst_ovf", DW'(overflow), DW'(0));
    check("rst_taken", DW'(input_taken), DW'(0));
    reset = 1'b0;
    @(negedge clk);

    full_tx(seq_vals(1), 32'h0000_00A5);
    full_tx(rand_vals() | {N_VALS{20'h00001}}, 32'h0000_0000);
    full_tx(seq_vals(20'h00100), 32'hFFFF_FFFF);
    v = rand_vals();
    v[0 +: W] = 20'hFFFFF;
    v[W +: W] = 20'h80000;
    full_tx(v, 32'h8000_0001);
    full_tx(rand_vals(), 32'h0F0F_0F0F);

    // Reset on the 10th BUSY cycle aborts the transaction.
    start_tx(seq_vals(1), 32'h0000_00A5, 1'b0);
    input_ready = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", DW'(state), DW'(0));
    check("midrst_dense", out_dense, DW'(0));
    check("midrst_count", DW'(out_count), DW'(0));
    check("midrst_ovf", DW'(overflow), DW'(0));
    check("midrst_taken", DW'(input_taken), DW'(0));
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    full_tx(seq_vals(1), 32'h0000_00A5);

    // input_ready held high through BUSY and DONE, then re-accept right after release.
    start_tx(rand_vals(), $urandom(), 1'b0);
    wait_done();
    hold_done(3);
    v = seq_vals(1);
    m = 32'h0000_00A5;
    in_vals = v;
    in_mask = m;
    release_done();
    start_tx(v, m, 1'b1);
    input_ready = 1'b0;
    wait_done();
    release_done();

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 3))
        0: m = $urandom();
        1: m = $urandom() & $urandom() & $urandom();
        2: m = $urandom() | $urandom();
        default: m = ~(32'h1 << $urandom_range(0, LENGTH - 1));
      endcase
      full_tx(rand_vals(), m);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
